// File: rtl/sbox_substitute.sv
// sbox_substitute: loads a byte S-box with its inverse, then substitutes a valid/ready byte stream
module sbox_substitute #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  output logic             table_ready,
  output logic             dup_error,
  input  logic             reload,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  localparam int N = 1 << WIDTH;
  typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;
  state_t           state_q;
  logic [WIDTH:0]   idx_q;
  logic [N-1:0]     seen_q;
  logic [WIDTH-1:0] fwd_q [N];
  logic [WIDTH-1:0] inv_q [N];
  logic             table_ready_q, dup_q, out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             accept, load_last, enter_load;
  logic [WIDTH-1:0] lookup;
  assign in_ready    = state_q == RUN && (!out_valid_q || out_ready);
  assign accept      = in_valid && in_ready;
  assign load_last   = idx_q == (WIDTH+1)'(N - 1);
  assign lookup      = mode ? inv_q[in_data] : fwd_q[in_data];
  assign enter_load  = (state_q == RUN && reload && !out_valid_q && !accept) || (state_q == DRAIN && !out_valid_q);
  assign table_ready = table_ready_q;
  assign dup_error   = dup_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  // Table RAM: forward entry at the load index, inverse entry keyed by the loaded value (last writer wins)
  always_ff @(posedge clk)
    if (!rst && state_q == LOAD && load_en) begin
      fwd_q[idx_q[WIDTH-1:0]] <= load_data;
      inv_q[load_data]        <= idx_q[WIDTH-1:0];
    end
  // Control: load sequencing, duplicate tracking, output register and reload/drain handling
  always_ff @(posedge clk)
    if (rst) begin
      state_q       <= LOAD;
      idx_q         <= '0;
      seen_q        <= '0;
      table_ready_q <= 1'b0;
      dup_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= lookup;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        LOAD: if (load_en) begin
          seen_q[load_data] <= 1'b1;
          if (seen_q[load_data]) dup_q <= 1'b1;
          idx_q <= idx_q + 1'b1;
          if (load_last) begin
            state_q       <= RUN;
            table_ready_q <= 1'b1;
          end
        end
        RUN:     if (reload) state_q <= enter_load ? LOAD : DRAIN;
        DRAIN:   if (!out_valid_q) state_q <= LOAD;
        default: state_q <= LOAD;
      endcase
      if (enter_load) begin
        idx_q         <= '0;
        seen_q        <= '0;
        table_ready_q <= 1'b0;
        dup_q         <= 1'b0;
      end
    end
endmodule

// File: tb/tb_sbox_substitute.sv
// tb_sbox_substitute: directed bench with a table/queue reference model checked every cycle
module tb_sbox_substitute;
  logic clk = 0, rst = 1, load_en = 0, reload = 0, mode = 0, in_valid = 0, out_ready = 0;
  logic [7:0] load_data = 0, in_data = 0;
  logic table_ready, dup_error, in_ready, out_valid;
  logic [7:0] out_data;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] tbl [256];
  logic [7:0] mfwd [256];
  logic [7:0] minv [256];
  bit mseen [256];
  int mcnt = 0, ms = 0;
  bit mtr = 0, mdup = 0, armed = 0;
  logic [7:0] q [$];
  logic [7:0] cap [$];
  logic [7:0] src [$];
  logic [7:0] orig [$];

  sbox_substitute #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_data(load_data),
    .table_ready(table_ready), .dup_error(dup_error), .reload(reload), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_enter_load;
    ms = 0; mcnt = 0; mtr = 0; mdup = 0;
    foreach (mseen[i]) mseen[i] = 0;
  endtask

  // Reference model: tables as plain arrays, output register as a queue of pending results
  always @(negedge clk) begin : mon
    logic ov, eir, acc;
    if (rst) begin
      model_enter_load();
      q.delete();
      armed = 1;
    end else if (armed) begin
      ov  = q.size() != 0;
      eir = ms == 1 && (!ov || out_ready);
      chk("in_ready", in_ready, eir);
      chk("out_valid", out_valid, ov);
      if (ov) chk("out_data", out_data, q[0]);
      chk("table_ready", table_ready, mtr);
      chk("dup_error", dup_error, mdup);
      acc = in_valid && eir;
      if (ov && out_ready) begin
        cap.push_back(out_data);
        void'(q.pop_front());
      end
      if (acc) q.push_back(mode ? minv[in_data] : mfwd[in_data]);
      case (ms)
        0: if (load_en) begin
          mfwd[mcnt] = load_data;
          minv[load_data] = mcnt[7:0];
          if (mseen[load_data]) mdup = 1;
          mseen[load_data] = 1;
          mcnt++;
          if (mcnt == 256) begin ms = 1; mtr = 1; end
        end
        1: if (reload) begin
          if (!ov && !acc) model_enter_load();
          else ms = 2;
        end
        default: if (!ov) model_enter_load();
      endcase
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      load_en = 1;
      load_data = tbl[i];
      tick();
    end
    load_en = 0;
  endtask

  task automatic do_reload;
    reload = 1;
    tick();
    reload = 0;
  endtask

  task automatic lookup(input logic m, input logic [7:0] x, input logic [7:0] e, input string nm);
    out_ready = 1;
    mode = m;
    in_data = x;
    in_valid = 1;
    tick();
    in_valid = 0;
    chk(nm, out_data, e);
    tick();
  endtask

  task automatic stream(input int m, input int pr, output int cyc);
    cyc = 0;
    while (src.size() > 0 && cyc < 20000) begin
      in_valid = 1;
      in_data = src[0];
      mode = (m == 2) ? 1'($urandom_range(1)) : 1'(m);
      out_ready = $urandom_range(99) < 32'(pr);
      #1;
      if (in_ready) void'(src.pop_front());
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 0;
    if (src.size() != 0) chk("stream_timeout", 1, 0);
    for (int k = 0; k < 1000 && out_valid; k++) begin
      out_ready = $urandom_range(99) < 32'(pr);
      tick();
    end
    chk("stream_drained", out_valid, 0);
    out_ready = 0;
  endtask

  initial begin
    int c, j;
    logic [7:0] t;
    tick(); tick();
    rst = 0;
    chk("rst_table_ready", table_ready, 0);
    chk("rst_dup_error", dup_error, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    // offset table with gaps in load_en
    for (int i = 0; i < 256; i++) tbl[i] = 8'(i + 8'h3B);
    load(0, 128);
    reload = 1; tick(); tick(); reload = 0;
    load(128, 255);
    chk("ofs_ready_255", table_ready, 0);
    load(255, 256);
    chk("ofs_ready_256", table_ready, 1);
    chk("ofs_dup", dup_error, 0);
    lookup(0, 8'h00, 8'h3B, "ofs_fwd_00");
    lookup(0, 8'hFF, 8'h3A, "ofs_fwd_ff");
    lookup(1, 8'h3B, 8'h00, "ofs_inv_3b");
    do_reload();
    // random permutation round trip
    for (int i = 0; i < 256; i++) tbl[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(i);
      t = tbl[i]; tbl[i] = tbl[j]; tbl[j] = t;
    end
    load(0, 256);
    src.delete(); orig.delete(); cap.delete();
    for (int i = 0; i < 1024; i++) begin
      t = 8'($urandom_range(255));
      src.push_back(t);
      orig.push_back(t);
    end
    stream(0, 100, c);
    chk("fwd_throughput", c, 1024);
    chk("fwd_count", cap.size(), 1024);
    src = cap;
    cap.delete();
    stream(1, 100, c);
    chk("inv_throughput", c, 1024);
    chk("inv_count", cap.size(), 1024);
    for (int i = 0; i < 1024 && i < cap.size(); i++) chk("roundtrip", cap[i], orig[i]);
    // backpressure with random out_ready and random mode
    src.delete(); cap.delete();
    for (int i = 0; i < 500; i++) src.push_back(8'($urandom_range(255)));
    stream(2, 50, c);
    chk("bp_count", cap.size(), 500);
    do_reload();
    // duplicate detection: entries 5 and 9 both 0x77
    for (int i = 0; i < 256; i++) tbl[i] = 8'(i + 8'h6E);
    tbl[5] = 8'h77;
    load(0, 9);
    chk("dup_before_10th", dup_error, 0);
    load(9, 10);
    chk("dup_after_10th", dup_error, 1);
    load(10, 256);
    chk("dup_ready", table_ready, 1);
    lookup(0, 8'd9, 8'h77, "dup_fwd9");
    lookup(0, 8'd5, 8'h77, "dup_fwd5");
    chk("dup_sticky_run", dup_error, 1);
    do_reload();
    chk("dup_cleared", dup_error, 0);
    // reset mid-load
    load(0, 100);
    rst = 1; tick(); rst = 0;
    chk("midrst_ready", table_ready, 0);
    for (int i = 0; i < 256; i++) tbl[i] = ~8'(i);
    load(0, 255);
    chk("midrst_ready_255", table_ready, 0);
    load(255, 256);
    chk("midrst_ready_256", table_ready, 1);
    lookup(0, 8'h12, 8'hED, "midrst_fwd");
    lookup(1, 8'hED, 8'h12, "midrst_inv");
    // load_en ignored while running
    load_en = 1; load_data = 8'h00; tick(); tick(); load_en = 0;
    lookup(0, 8'h40, 8'hBF, "run_ignores_load");
    // reload with a pending output
    out_ready = 0; mode = 0; in_data = 8'h40; in_valid = 1;
    tick();
    in_valid = 0;
    chk("pend_valid", out_valid, 1);
    chk("pend_data", out_data, 8'hBF);
    reload = 1; tick(); reload = 0;
    chk("drain_in_ready", in_ready, 0);
    chk("drain_table_ready", table_ready, 1);
    tick();
    chk("drain_hold_data", out_data, 8'hBF);
    out_ready = 1;
    tick();
    chk("drain_delivered", out_valid, 0);
    tick();
    chk("after_drain_ready", table_ready, 0);
    chk("after_drain_in_ready", in_ready, 0);
    for (int i = 0; i < 256; i++) tbl[i] = 8'(i) ^ 8'h5A;
    load(0, 256);
    lookup(0, 8'h00, 8'h5A, "new_fwd");
    lookup(1, 8'h5A, 8'h00, "new_inv");
    lookup(0, 8'h01, 8'h5B, "new_fwd1");
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
